// File: rtl/sqrt_pkg.sv
// Shared definitions for the square-root datapath: FSM states and width helpers.
package sqrt_pkg;

    localparam int unsigned SQRT_N = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n / 2);
    endfunction

    localparam int unsigned SQRT_CNT_W = cnt_width(SQRT_N);

endpackage

// File: rtl/square_reconstruct.sv
// Rebuilds num = root^2 + rem with one multiplier bit per clock (shift-add),
// flagging non-canonical pairs where rem > 2*root.
module square_reconstruct
    import sqrt_pkg::*;
#(
    parameter int unsigned N = SQRT_N
) (
    input  logic             Clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [N/2-1:0]   root_in,
    input  logic [N/2:0]     rem_in,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     num_out,
    output logic             err
);

    localparam int unsigned H  = N / 2;
    localparam int unsigned CW = cnt_width(N);

    state_t        state;
    state_t        state_nxt;
    logic [N:0]    acc;
    logic [N:0]    mcand;
    logic [H-1:0]  q_sr;
    logic [CW-1:0] cnt;
    logic          last;
    logic          err_next;
    logic          accept;
    logic          unused_carry;

    // Bit N only absorbs carries from non-canonical pairs; the result is mod 2^N.
    assign unused_carry = acc[N];
    assign accept       = start && (state != CALC);

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? CALC : IDLE;
            CALC:    state_nxt = last ? DONE : CALC;
            DONE:    state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    // The final iteration raises 'last'; the following edge publishes the sum.
    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            mcand    <= '0;
            q_sr     <= '0;
            cnt      <= '0;
            last     <= 1'b0;
            err_next <= 1'b0;
            num_out  <= '0;
            err      <= 1'b0;
        end else if (accept) begin
            mcand    <= {{(H + 1){1'b0}}, root_in};
            q_sr     <= root_in;
            acc      <= {{H{1'b0}}, rem_in};
            cnt      <= '0;
            last     <= 1'b0;
            err_next <= (rem_in > {root_in, 1'b0});
        end else if (state == CALC) begin
            if (last) begin
                num_out <= acc[N-1:0];
                err     <= err_next;
            end else begin
                if (q_sr[0]) begin
                    acc <= acc + (mcand << cnt);
                end
                q_sr <= q_sr >> 1;
                cnt  <= cnt + 1'b1;
                last <= (cnt == CW'(H - 1));
            end
        end
    end

endmodule

// File: tb/tb_square_reconstruct.sv
// Scoreboard bench for square_reconstruct: driver queues expected results, monitor checks each done.
module tb_square_reconstruct;

    localparam int unsigned N   = 32;
    localparam int unsigned LAT = N / 2 + 1;

    typedef struct {
        logic [31:0] num;
        logic        err;
        int unsigned cyc;
    } exp_t;

    logic          Clock;
    logic          reset_n;
    logic          start;
    logic [15:0]   root_in;
    logic [16:0]   rem_in;
    logic          busy;
    logic          done;
    logic [31:0]   num_out;
    logic          err;

    exp_t          exp_q[$];
    int unsigned   cyc;
    int            checks;
    int            errors;

    square_reconstruct #(.N(N)) dut (
        .Clock   (Clock),
        .reset_n (reset_n),
        .start   (start),
        .root_in (root_in),
        .rem_in  (rem_in),
        .busy    (busy),
        .done    (done),
        .num_out (num_out),
        .err     (err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: plain arithmetic on the pair, independent of the shift-add schedule.
    function automatic exp_t model(input logic [15:0] q, input logic [16:0] r);
        exp_t e;
        logic [63:0] full;
        full  = 64'(q) * 64'(q) + 64'(r);
        e.num = full[31:0];
        e.err = (64'(r) > 64'(q) * 2);
        e.cyc = 0;
        return e;
    endfunction

    function automatic logic [15:0] isqrt(input logic [31:0] n);
        logic [15:0] q;
        logic [15:0] t;
        q = '0;
        for (int b = 15; b >= 0; b--) begin
            t = q | (16'd1 << b);
            if (64'(t) * 64'(t) <= 64'(n)) q = t;
        end
        return q;
    endfunction

    task automatic issue_push(input logic [15:0] q, input logic [16:0] r, input exp_t e);
        start   = 1'b1;
        root_in = q;
        rem_in  = r;
        @(posedge Clock);
        #1;
        e.cyc = cyc + LAT;
        exp_q.push_back(e);
        start = 1'b0;
    endtask

    task automatic issue(input logic [15:0] q, input logic [16:0] r);
        issue_push(q, r, model(q, r));
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 3 * LAT && !seen; i++) begin
            @(negedge Clock);
            if (done) seen = 1;
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
    endtask

    always @(negedge Clock) begin
        if (busy && done) chk("busy_done_exclusive", 64'd1, 64'd0);
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("num_out", 64'(num_out), 64'(e.num));
                chk("err", 64'(err), 64'(e.err));
                chk("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        exp_t e;
        logic [31:0] n;
        logic [15:0] q;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        root_in = '0;
        rem_in  = '0;
        repeat (3) @(posedge Clock);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_num", 64'(num_out), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        @(negedge Clock);
        reset_n = 1'b1;

        issue(16'd3, 17'd2);
        for (int i = 0; i < LAT; i++) begin
            @(negedge Clock);
            chk("busy_during_calc", 64'(busy), 64'd1);
        end
        wait_done();

        issue(16'hFFFF, 17'h1FFFE);
        wait_done();
        issue(16'd0, 17'd0);
        wait_done();

        e.num = 32'd36; e.err = 1'b1;
        issue_push(16'd5, 17'd11, e);
        wait_done();
        e.num = 32'd0; e.err = 1'b1;
        issue_push(16'hFFFF, 17'h1FFFF, e);
        wait_done();

        // Start pulsed mid-CALC must be ignored; then back-to-back start in DONE.
        issue(16'd100, 17'd50);
        repeat (4) @(posedge Clock);
        #1;
        start = 1'b1; root_in = 16'd7; rem_in = 17'd0;
        @(posedge Clock);
        #1;
        start = 1'b0;
        wait_done();
        e.num = 32'd1000; e.err = 1'b0;
        issue_push(16'd31, 17'd39, e);
        wait_done();

        // Asynchronous reset mid-operation discards the result.
        issue(16'd1234, 17'd99);
        repeat (8) @(posedge Clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_done", 64'(done), 64'd0);
        chk("midreset_num", 64'(num_out), 64'd0);
        chk("midreset_err", 64'(err), 64'd0);
        exp_q.delete();
        repeat (5) @(posedge Clock);
        @(negedge Clock);
        reset_n = 1'b1;
        repeat (2 * LAT) @(posedge Clock);
        #1;
        issue(16'd200, 17'd7);
        wait_done();

        // Loopback against a behavioural square root, issued back-to-back.
        for (int k = 0; k < 1000; k++) begin
            n     = $urandom;
            q     = isqrt(n);
            e.num = n;
            e.err = 1'b0;
            issue_push(q, 17'(n - 32'(q) * 32'(q)), e);
            wait_done();
        end

        for (int k = 0; k < 100; k++) begin
            issue(16'($urandom), 17'($urandom));
            wait_done();
        end

        repeat (3) @(posedge Clock);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
